// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sprite_pkg
// Purpose  : Shared types and helpers for the sprite renderer slice.
//            rgb4_t      - 12-bit pixel (4 bits per channel)
//            c_RGB_ZERO  - black / blanked pixel
//            rom_pattern - built-in sprite test image, one palette index
//                          per ROM address (low bits are kept by the ROM)
// Revision : 1.0 - initial release
// ============================================================================
package sprite_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb4_t;

  localparam rgb4_t c_RGB_ZERO = '{4'h0, 4'h0, 4'h0};

  // Built-in image: mixes column, row and frame bits so that neighbouring
  // pixels, mirrored columns and successive frames all differ.
  function automatic int rom_pattern(input int addr);
    return addr + (addr >>> 2) + (addr >>> 8) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_rom.sv
`default_nettype none
// ============================================================================
// Module   : sprite_rom
// Purpose  : Sprite pixel ROM, synchronous read (one clock of latency).
// Ports    : vga_clk  - clock
//            reset_n  - async active-low reset, clears the read register
//            addr     - read address, $clog2(DEPTH) bits
//            data     - palette index of the addressed pixel, DATA_W bits
// Params   : DEPTH, DATA_W, INIT_FILE ("" = built-in test image, any other
//            name selects the alternate, bit-inverted test image)
// Revision : 1.0 - initial release
// ============================================================================
module sprite_rom
  import sprite_pkg::*;
#(
  parameter int    DEPTH     = 1024,
  parameter int    DATA_W    = 2,
  parameter string INIT_FILE = ""
) (
  input  logic                     vga_clk,
  input  logic                     reset_n,
  input  logic [$clog2(DEPTH)-1:0] addr,
  output logic [DATA_W-1:0]        data
);

  localparam bit c_BUILTIN = (INIT_FILE == "");

  logic [DATA_W-1:0] w_word;

  always_comb begin
    w_word = DATA_W'(rom_pattern(int'(addr)));
    if (!c_BUILTIN) begin
      w_word = ~w_word;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= '0;
    end else begin
      data <= w_word;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sprite_renderer.sv
`default_nettype none
// ============================================================================
// Module   : sprite_renderer
// Purpose  : Composites one animated, optionally mirrored sprite over the
//            background video stream. Two-cycle pipeline: ROM read stage,
//            then palette lookup / mux into the output registers.
// Ports    : vga_clk, reset_n           - clock, async active-low reset
//            DrawX, DrawY               - current beam pixel (10 b)
//            SpriteX, SpriteY           - sprite top-left corner (10 b)
//            blank                      - high during active video
//            vsync_pulse                - one-cycle frame start strobe
//            sprite_en, anim_en, flip_x - visibility / animation / mirror
//            bg_red, bg_green, bg_blue  - background pixel at DrawX/DrawY
//            red, green, blue           - composited pixel (2 cycles later)
//            sprite_hit                 - opaque sprite pixel was drawn
// Revision : 1.0 - initial release
// ============================================================================
module sprite_renderer
  import sprite_pkg::*;
#(
  parameter int SPR_W      = 16,
  parameter int SPR_H      = 16,
  parameter int IDX_W      = 2,
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_DIV  = 8,
  parameter int TRANSP_IDX = 0
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] SpriteX,
  input  logic [9:0] SpriteY,
  input  logic       blank,
  input  logic       vsync_pulse,
  input  logic       sprite_en,
  input  logic       anim_en,
  input  logic       flip_x,
  input  logic [3:0] bg_red,
  input  logic [3:0] bg_green,
  input  logic [3:0] bg_blue,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       sprite_hit
);

  localparam int c_FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int c_DEPTH   = NUM_FRAMES * SPR_W * SPR_H;
  localparam int c_ADDR_W  = $clog2(c_DEPTH);

  logic [10:0]          w_rel_x;
  logic [10:0]          w_rel_y;
  logic [10:0]          w_col;
  logic                 w_in_box;
  logic [c_ADDR_W-1:0]  w_addr;
  logic [IDX_W-1:0]     w_idx;
  rgb4_t                w_pix;
  logic                 w_hit;

  logic [7:0]           r_vs_cnt;
  logic [c_FRAME_W-1:0] r_frame;
  logic                 r_in_box;
  logic                 r_sprite_en;
  logic                 r_blank;
  rgb4_t                r_bg;
  logic [1:0]           r_live;

  // 11-bit unsigned difference: a beam left of / above the sprite wraps to
  // a huge value, so it can never land inside the box.
  assign w_rel_x  = {1'b0, DrawX} - {1'b0, SpriteX};
  assign w_rel_y  = {1'b0, DrawY} - {1'b0, SpriteY};
  assign w_in_box = (w_rel_x < 11'(SPR_W)) && (w_rel_y < 11'(SPR_H));
  assign w_col    = flip_x ? (11'(SPR_W - 1) - w_rel_x) : w_rel_x;
  assign w_addr   = c_ADDR_W'(r_frame) * c_ADDR_W'(SPR_W * SPR_H)
                  + c_ADDR_W'(w_rel_y) * c_ADDR_W'(SPR_W)
                  + c_ADDR_W'(w_col);

  sprite_rom #(
    .DEPTH  (c_DEPTH),
    .DATA_W (IDX_W)
  ) u_rom (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .addr    (w_addr),
    .data    (w_idx)
  );

  function automatic rgb4_t palette(input logic [3:0] idx);
    rgb4_t c;
    case (idx)
      4'd0:    c = '{4'h0, 4'h0, 4'h0};
      4'd1:    c = '{4'hF, 4'h0, 4'h0};
      4'd2:    c = '{4'h0, 4'hF, 4'h0};
      4'd3:    c = '{4'h0, 4'h0, 4'hF};
      default: c = '{idx, ~idx, idx};
    endcase
    return c;
  endfunction

  always_comb begin
    w_pix = c_RGB_ZERO;
    w_hit = 1'b0;
    if (r_blank) begin
      if (r_in_box && r_sprite_en && (w_idx != IDX_W'(TRANSP_IDX))) begin
        w_pix = palette(4'(w_idx));
        w_hit = 1'b1;
      end else begin
        w_pix = r_bg;
      end
    end
  end

  // Animation: frame only moves on a vsync_pulse cycle, so it is stable
  // for every pixel of a displayed frame.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vs_cnt <= '0;
      r_frame  <= '0;
    end else if (vsync_pulse && anim_en) begin
      if (r_vs_cnt == 8'(FRAME_DIV - 1)) begin
        r_vs_cnt <= '0;
        if (r_frame == c_FRAME_W'(NUM_FRAMES - 1)) begin
          r_frame <= '0;
        end else begin
          r_frame <= r_frame + c_FRAME_W'(1);
        end
      end else begin
        r_vs_cnt <= r_vs_cnt + 8'd1;
      end
    end
  end

  // Stage 1 runs alongside the ROM read. r_live keeps the outputs black
  // for the first two edges after reset release, until real pixels have
  // flowed through both stages.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_box    <= 1'b0;
      r_sprite_en <= 1'b0;
      r_blank     <= 1'b0;
      r_bg        <= c_RGB_ZERO;
      r_live      <= 2'b00;
    end else begin
      r_in_box    <= w_in_box;
      r_sprite_en <= sprite_en;
      r_blank     <= blank;
      r_bg        <= '{bg_red, bg_green, bg_blue};
      r_live      <= {r_live[0], 1'b1};
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      red        <= 4'h0;
      green      <= 4'h0;
      blue       <= 4'h0;
      sprite_hit <= 1'b0;
    end else if (r_live[1]) begin
      red        <= w_pix.r;
      green      <= w_pix.g;
      blue       <= w_pix.b;
      sprite_hit <= w_hit;
    end else begin
      red        <= 4'h0;
      green      <= 4'h0;
      blue       <= 4'h0;
      sprite_hit <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_renderer
// Purpose  : Self-checking bench for sprite_renderer (FRAME_DIV = 2).
//            Expected pixels are hand-derived from the built-in ROM image
//            idx = (a + a/4 + a/256 + 1) mod 4 and the palette
//            1 = F00, 2 = 0F0, 3 = 00F, 0 = transparent.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_renderer;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic [9:0] DrawX, DrawY, SpriteX, SpriteY;
  logic       blank, vsync_pulse, sprite_en, anim_en, flip_x;
  logic [3:0] bg_red, bg_green, bg_blue;
  logic [3:0] red, green, blue;
  logic       sprite_hit;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 vga_clk = ~vga_clk;

  sprite_renderer #(
    .FRAME_DIV  (2),
    .NUM_FRAMES (4)
  ) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .SpriteX     (SpriteX),
    .SpriteY     (SpriteY),
    .blank       (blank),
    .vsync_pulse (vsync_pulse),
    .sprite_en   (sprite_en),
    .anim_en     (anim_en),
    .flip_x      (flip_x),
    .bg_red      (bg_red),
    .bg_green    (bg_green),
    .bg_blue     (bg_blue),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .sprite_hit  (sprite_hit)
  );

  typedef struct packed {
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic [9:0]  sx;
    logic [9:0]  sy;
    logic        bl;
    logic        en;
    logic        fl;
    logic [11:0] bg;
    logic [11:0] exp_rgb;
    logic        exp_hit;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [11:0] exp_rgb, input logic exp_hit);
    tests_run++;
    if ({red, green, blue} !== exp_rgb || sprite_hit !== exp_hit) begin
      tests_failed++;
      $display("FAIL %s: got rgb=%h hit=%b, expected rgb=%h hit=%b",
               nm, {red, green, blue}, sprite_hit, exp_rgb, exp_hit);
    end
  endtask

  task automatic drive(input vec_t v);
    DrawX = v.dx; DrawY = v.dy; SpriteX = v.sx; SpriteY = v.sy;
    blank = v.bl; sprite_en = v.en; flip_x = v.fl;
    {bg_red, bg_green, bg_blue} = v.bg;
  endtask

  task automatic pulse(input logic anim);
    vsync_pulse = 1'b1;
    anim_en = anim;
    tick();
    vsync_pulse = 1'b0;
    tick();
  endtask

  task automatic probe(input string nm, input logic [11:0] exp_rgb, input logic exp_hit);
    tick();
    tick();
    check(nm, exp_rgb, exp_hit);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] frame_exp [4];
    logic        frame_hit [4];
    vec_t        probe_v;
    vec_t        outside_v;

    //        dx       dy      sx       sy     bl    en    fl    bg       exp      hit
    vecs[0]  = '{10'd100, 10'd50, 10'd100, 10'd50, 1'b1, 1'b1, 1'b0, 12'h123, 12'hF00, 1'b1};
    vecs[1]  = '{10'd99,  10'd50, 10'd100, 10'd50, 1'b1, 1'b1, 1'b0, 12'h123, 12'h123, 1'b0};
    vecs[2]  = '{10'd116, 10'd50, 10'd100, 10'd50, 1'b1, 1'b1, 1'b0, 12'h123, 12'h123, 1'b0};
    vecs[3]  = '{10'd115, 10'd50, 10'd100, 10'd50, 1'b1, 1'b1, 1'b0, 12'h123, 12'h00F, 1'b1};
    vecs[4]  = '{10'd5,   10'd50, 10'd630, 10'd50, 1'b1, 1'b1, 1'b0, 12'h123, 12'h123, 1'b0};
    vecs[5]  = '{10'd103, 10'd50, 10'd100, 10'd50, 1'b1, 1'b1, 1'b0, 12'hABC, 12'hABC, 1'b0};
    vecs[6]  = '{10'd100, 10'd50, 10'd100, 10'd50, 1'b0, 1'b1, 1'b0, 12'hABC, 12'h000, 1'b0};
    vecs[7]  = '{10'd100, 10'd50, 10'd100, 10'd50, 1'b1, 1'b1, 1'b1, 12'h123, 12'h00F, 1'b1};
    vecs[8]  = '{10'd115, 10'd50, 10'd100, 10'd50, 1'b1, 1'b1, 1'b1, 12'h123, 12'hF00, 1'b1};
    vecs[9]  = '{10'd100, 10'd50, 10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 12'h456, 12'h456, 1'b0};
    vecs[10] = '{10'd101, 10'd51, 10'd100, 10'd50, 1'b1, 1'b1, 1'b0, 12'h123, 12'h0F0, 1'b1};
    vecs[11] = '{10'd100, 10'd65, 10'd100, 10'd50, 1'b1, 1'b1, 1'b0, 12'h123, 12'hF00, 1'b1};
    vecs[12] = '{10'd100, 10'd66, 10'd100, 10'd50, 1'b1, 1'b1, 1'b0, 12'h789, 12'h789, 1'b0};

    probe_v   = vecs[0];
    outside_v = vecs[1];

    // frame f seen at the sprite's top-left pixel: idx = (f + 1) mod 4
    frame_exp[0] = 12'hF00; frame_hit[0] = 1'b1;
    frame_exp[1] = 12'h0F0; frame_hit[1] = 1'b1;
    frame_exp[2] = 12'h00F; frame_hit[2] = 1'b1;
    frame_exp[3] = 12'h123; frame_hit[3] = 1'b0;

    reset_n = 1'b0;
    vsync_pulse = 1'b0;
    anim_en = 1'b0;
    drive(probe_v);
    repeat (3) tick();
    check("reset_state", 12'h000, 1'b0);
    @(negedge vga_clk);
    reset_n = 1'b1;
    repeat (3) tick();

    // Steady-state vectors
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i]);
      tick();
      tick();
      check($sformatf("vec%0d", i), vecs[i].exp_rgb, vecs[i].exp_hit);
    end

    // Exactly two cycles of latency: one sprite pixel between background pixels
    drive(outside_v);
    tick(); tick();
    drive(probe_v);
    tick();
    check("latency_edge1", 12'h123, 1'b0);
    drive(outside_v);
    tick();
    check("latency_edge2", 12'hF00, 1'b1);
    tick();
    check("latency_edge3", 12'h123, 1'b0);

    // Animation with FRAME_DIV = 2: frames 0,1,2,3,0 over 8 pulses
    drive(probe_v);
    probe("frame_start", frame_exp[0], frame_hit[0]);
    for (int k = 1; k <= 4; k++) begin
      pulse(1'b1);
      pulse(1'b1);
      probe($sformatf("frame_step%0d", k), frame_exp[k % 4], frame_hit[k % 4]);
    end

    // Counters hold (no clear) while anim_en is low
    pulse(1'b1);
    probe("half_step", frame_exp[0], frame_hit[0]);
    pulse(1'b0);
    pulse(1'b0);
    pulse(1'b0);
    probe("anim_off", frame_exp[0], frame_hit[0]);
    pulse(1'b1);
    probe("count_held", frame_exp[1], frame_hit[1]);

    // vsync_pulse held high for two cycles counts twice
    vsync_pulse = 1'b1;
    anim_en = 1'b1;
    tick();
    tick();
    vsync_pulse = 1'b0;
    anim_en = 1'b0;
    probe("vsync_held", frame_exp[2], frame_hit[2]);

    // Asynchronous reset mid-frame with frame = 2
    @(posedge vga_clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_clear", 12'h000, 1'b0);
    @(negedge vga_clk);
    reset_n = 1'b1;
    tick();
    check("release_edge1", 12'h000, 1'b0);
    tick();
    check("release_edge2", 12'h000, 1'b0);
    tick();
    check("release_edge3", frame_exp[0], frame_hit[0]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
